ahb_lite_ws_mem_slave: RTL

AHB-Lite responder (slave) backed by a word-organised memory. It inserts a parameterised number of wait states per transfer and returns the two-cycle ERROR response for illegal accesses. It is the second slave planned behind the address decoder / read-data mux, alongside the existing zero-wait slave, and is driven by the AHB-Lite master task model.

---
 rtl/ahb_lite_ws_mem_slave_pkg.sv | 40 ++++
 rtl/ahb_lite_byte_lane_ram.sv | 26 ++
 rtl/ahb_lite_ws_mem_slave.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ahb_lite_ws_mem_slave_pkg.sv
// Shared AHB-Lite codes and slave state encoding for the wait-state memory slave.
// Everything the top module and its memory need to agree on lives here.
package ahb_lite_ws_mem_slave_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic {
    HRESP_OKAY  = 1'b0,
    HRESP_ERROR = 1'b1
  } hresp_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } slv_state_e;

  // Sizes above a word are rejected separately, so only byte/half/word matter here.
  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    if (size == 3'(HSIZE_HALF))      bad = lo[0];
    else if (size == 3'(HSIZE_WORD)) bad = |lo;
    return bad;
  endfunction

endpackage

// File: rtl/ahb_lite_byte_lane_ram.sv
// DEPTH x 32 word memory with per-byte write strobes, synchronous write and
// asynchronous read, so a word written at one edge is visible right after it.
module ahb_lite_byte_lane_ram #(
  parameter int DEPTH = 64,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    we_i,
  input  logic [IW-1:0] idx_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  // NOTE: the storage array has no reset branch on purpose; resetting it would
  // turn a plain RAM into thousands of flops and the contents are undefined anyway.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i[b]) mem[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
    end
  end

  assign rdata_o = mem[idx_i];

endmodule

// File: rtl/ahb_lite_ws_mem_slave.sv
// AHB-Lite responder over a word memory: WAIT_STATES low-ready cycles per OKAY
// transfer, two-cycle ERROR for out-of-range, oversized or misaligned accesses.
module ahb_lite_ws_mem_slave
  import ahb_lite_ws_mem_slave_pkg::*;
#(
  parameter int DEPTH       = 64,
  parameter int WAIT_STATES = 1,
  parameter int AW          = 32
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [AW-1:0] HADDR,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [2:0]    HBURST,
  input  logic [3:0]    HPROT,
  input  logic [1:0]    HTRANS,
  input  logic          HMASTLOCK,
  input  logic          HREADY,
  input  logic [31:0]   HWDATA,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA
);

  localparam int            IW         = $clog2(DEPTH);
  localparam int            LW         = IW + 2;
  localparam logic [3:0]    WS_LOAD    = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
  localparam logic [AW-1:0] ADDR_LIMIT = AW'(4 * DEPTH);

  slv_state_e    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [LW-1:0] addr_q, addr_d;
  logic          write_q, write_d;
  logic [1:0]    size_q, size_d;
  logic          ready_q;
  hresp_e        resp_q;

  logic          accept;
  logic          req_err;
  logic [3:0]    mem_we;
  logic [31:0]   mem_rdata;
  logic          unused_sideband;

  // Burst type, protection and lock carry no meaning for a plain memory.
  assign unused_sideband = ^{HBURST, HPROT, HMASTLOCK};

  function automatic logic [3:0] lane_strobe(input logic [1:0] size, input logic [1:0] lo);
    logic [3:0] strb;
    case (size)
      2'd0:    strb = 4'b0001 << lo;
      2'd1:    strb = lo[1] ? 4'b1100 : 4'b0011;
      default: strb = 4'b1111;
    endcase
    return strb;
  endfunction

  // New address phases are only looked at in cycles where this slave drives ready high.
  assign accept = (state_q inside {ST_IDLE, ST_DATA, ST_ERR2}) && HSEL && HREADY &&
                  (HTRANS == 2'(HTRANS_NONSEQ) || HTRANS == 2'(HTRANS_SEQ));

  assign req_err = (HADDR >= ADDR_LIMIT) || (HSIZE > 3'(HSIZE_WORD)) ||
                   misaligned(HSIZE, HADDR[1:0]);

  // NOTE: every signal written here gets a default first, so no path can leave
  // one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    write_d = write_q;
    size_d  = size_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR[LW-1:0];
          write_d = HWRITE;
          size_d  = HSIZE[1:0];
          if (req_err) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      size_q  <= size_d;
      ready_q <= state_d inside {ST_IDLE, ST_DATA, ST_ERR2};
      resp_q  <= (state_d inside {ST_ERR1, ST_ERR2}) ? HRESP_ERROR : HRESP_OKAY;
    end
  end

  // A write commits at the edge closing its DATA cycle; reset at that edge drops it.
  assign mem_we = (state_q == ST_DATA && write_q && HRESETn) ?
                  lane_strobe(size_q, addr_q[1:0]) : 4'b0000;

  ahb_lite_byte_lane_ram #(
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_ram (
    .clk     (HCLK),
    .we_i    (mem_we),
    .idx_i   (addr_q[LW-1:2]),
    .wdata_i (HWDATA),
    .rdata_o (mem_rdata)
  );

  assign HREADYOUT = ready_q;
  assign HRESP     = resp_q;
  assign HRDATA    = ((state_q == ST_WAIT || state_q == ST_DATA) && !write_q) ? mem_rdata : 32'd0;

endmodule
